// File: rtl/kfmmc_arbiter_pkg.sv
// Shared state encodings, strobe indices and byte helpers for the KFMMC access arbiter.
package kfmmc_arbiter_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE       = 4'd0;
    localparam state_t ST_ADDR1      = 4'd1;
    localparam state_t ST_ADDR2      = 4'd2;
    localparam state_t ST_ADDR3      = 4'd3;
    localparam state_t ST_ADDR4      = 4'd4;
    localparam state_t ST_CMD        = 4'd5;
    localparam state_t ST_WAIT_BUSY  = 4'd6;
    localparam state_t ST_WAIT_EVENT = 4'd7;
    localparam state_t ST_RD_STROBE  = 4'd8;
    localparam state_t ST_RD_CAPTURE = 4'd9;
    localparam state_t ST_RD_HOLD    = 4'd10;
    localparam state_t ST_DONE       = 4'd11;

    localparam int STB_ADDR1 = 0;
    localparam int STB_ADDR2 = 1;
    localparam int STB_ADDR3 = 2;
    localparam int STB_ADDR4 = 3;
    localparam int STB_CMD   = 4;
    localparam int STB_READ  = 5;
    localparam int STB_COUNT = 6;

    // idx 3 selects the most significant byte.
    function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [1:0] idx);
        return 8'(addr >> {idx, 3'b000});
    endfunction

    function automatic logic [1:0] one_hot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/kfmmc_round_robin_2.sv
// Two-way round-robin selector: on contention the requester not granted last wins.
module kfmmc_round_robin_2 (
    input  logic [1:0] request,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |request;
        grant       = (request == 2'b11) ? ~last : request[1];
    end

endmodule

// File: rtl/kfmmc_access_arbiter.sv
// Arbitrates two requesters onto the KFMMC drive: address/command write, block reads, completion.
module kfmmc_access_arbiter
    import kfmmc_arbiter_pkg::*;
#(
    parameter int BLOCK_BYTES      = 512,
    parameter int DEFAULT_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_block_address_0,
    input  logic [31:0] req_block_address_1,
    input  logic [7:0]  req_command_0,
    input  logic [7:0]  req_command_1,
    output logic [1:0]  rd_valid,
    input  logic [1:0]  rd_ready,
    output logic [7:0]  rd_data,
    output logic [1:0]  done,
    output logic        done_interface_error,
    output logic        done_crc_error,
    output logic [7:0]  internal_data_bus,
    output logic        write_block_address_1,
    output logic        write_block_address_2,
    output logic        write_block_address_3,
    output logic        write_block_address_4,
    output logic        write_access_command,
    output logic        read_data,
    input  logic [7:0]  read_data_byte,
    input  logic        drive_busy,
    input  logic        read_interface_error,
    input  logic        read_crc_error,
    input  logic        block_read_interrupt,
    input  logic        read_completion_interrupt,
    output logic        owner,
    output logic        busy
);

    localparam logic       LP_DEFAULT     = 1'(DEFAULT_PRIORITY);
    localparam logic [9:0] LP_BLOCK_BYTES = 10'(BLOCK_BYTES);

    state_t               r_state;
    state_t               w_next;
    logic                 r_run;
    logic                 r_owner;
    logic [31:0]          r_addr;
    logic [7:0]           r_cmd;
    logic [7:0]           r_rd_data;
    logic [9:0]           r_count;
    logic                 r_pending;
    logic                 r_blk_q;
    logic                 r_cmp_q;
    logic                 w_grant;
    logic                 w_grant_valid;
    logic                 w_grant_fire;
    logic                 w_blk_edge;
    logic                 w_cmp_edge;
    logic                 w_accept;
    logic                 w_hold_pending;
    logic [STB_COUNT-1:0] w_strobe;
    logic [7:0]           w_bus;

    kfmmc_round_robin_2 u_rr (
        .request     (req_valid),
        .last        (r_owner),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // r_run keeps req_ready low while reset is held and for the first edge after release.
    assign w_grant_fire   = (r_state == ST_IDLE) && r_run && w_grant_valid;
    assign w_blk_edge     = block_read_interrupt & ~r_blk_q;
    assign w_cmp_edge     = read_completion_interrupt & ~r_cmp_q;
    assign w_accept       = (r_state == ST_RD_HOLD) && rd_ready[r_owner];
    assign w_hold_pending = (r_state == ST_RD_STROBE) || (r_state == ST_RD_CAPTURE) ||
                            (r_state == ST_RD_HOLD) || ((r_state == ST_WAIT_EVENT) && w_blk_edge);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_grant_fire) w_next = ST_ADDR1;
            ST_ADDR1:      w_next = ST_ADDR2;
            ST_ADDR2:      w_next = ST_ADDR3;
            ST_ADDR3:      w_next = ST_ADDR4;
            ST_ADDR4:      w_next = ST_CMD;
            ST_CMD:        w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (w_cmp_edge)      w_next = ST_DONE;
                else if (drive_busy) w_next = ST_WAIT_EVENT;
            end
            ST_WAIT_EVENT: begin
                if (w_blk_edge)                   w_next = ST_RD_STROBE;
                else if (w_cmp_edge || r_pending) w_next = ST_DONE;
            end
            ST_RD_STROBE:  w_next = ST_RD_CAPTURE;
            ST_RD_CAPTURE: w_next = ST_RD_HOLD;
            ST_RD_HOLD: begin
                if (w_accept) begin
                    if (r_count != 10'd1)             w_next = ST_RD_STROBE;
                    else if (r_pending || w_cmp_edge) w_next = ST_DONE;
                    else                              w_next = ST_WAIT_EVENT;
                end
            end
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_run     <= 1'b0;
            r_owner   <= ~LP_DEFAULT;
            r_addr    <= 32'h0;
            r_cmd     <= 8'h00;
            r_rd_data <= 8'h00;
            r_count   <= 10'd0;
            r_pending <= 1'b0;
            r_blk_q   <= 1'b0;
            r_cmp_q   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            r_blk_q <= block_read_interrupt;
            r_cmp_q <= read_completion_interrupt;
            if (w_grant_fire) begin
                r_owner <= w_grant;
                r_addr  <= w_grant ? req_block_address_1 : req_block_address_0;
                r_cmd   <= w_grant ? req_command_1 : req_command_0;
            end
            if (r_state == ST_RD_CAPTURE) r_rd_data <= read_data_byte;
            if ((r_state == ST_WAIT_EVENT) && w_blk_edge) r_count <= LP_BLOCK_BYTES;
            else if (w_accept)                            r_count <= r_count - 10'd1;
            // A completion seen mid-block is remembered until the block has drained.
            if (r_state == ST_DONE)                r_pending <= 1'b0;
            else if (w_cmp_edge && w_hold_pending) r_pending <= 1'b1;
        end
    end

    always_comb begin
        w_strobe = '0;
        w_bus    = 8'h00;
        case (r_state)
            ST_ADDR1: begin w_strobe[STB_ADDR1] = 1'b1; w_bus = addr_byte(r_addr, 2'd3); end
            ST_ADDR2: begin w_strobe[STB_ADDR2] = 1'b1; w_bus = addr_byte(r_addr, 2'd2); end
            ST_ADDR3: begin w_strobe[STB_ADDR3] = 1'b1; w_bus = addr_byte(r_addr, 2'd1); end
            ST_ADDR4: begin w_strobe[STB_ADDR4] = 1'b1; w_bus = addr_byte(r_addr, 2'd0); end
            ST_CMD:   begin w_strobe[STB_CMD]   = 1'b1; w_bus = r_cmd; end
            ST_RD_STROBE: w_strobe[STB_READ] = 1'b1;
            default: ;
        endcase
    end

    assign write_block_address_1 = w_strobe[STB_ADDR1];
    assign write_block_address_2 = w_strobe[STB_ADDR2];
    assign write_block_address_3 = w_strobe[STB_ADDR3];
    assign write_block_address_4 = w_strobe[STB_ADDR4];
    assign write_access_command  = w_strobe[STB_CMD];
    assign read_data             = w_strobe[STB_READ];
    assign internal_data_bus     = w_bus;

    assign req_ready            = w_grant_fire ? one_hot2(w_grant) : 2'b00;
    assign rd_valid             = (r_state == ST_RD_HOLD) ? one_hot2(r_owner) : 2'b00;
    assign done                 = (r_state == ST_DONE) ? one_hot2(r_owner) : 2'b00;
    assign done_interface_error = (r_state == ST_DONE) && read_interface_error;
    assign done_crc_error       = (r_state == ST_DONE) && read_crc_error;
    assign rd_data              = r_rd_data;
    assign owner                = r_owner;
    assign busy                 = (r_state != ST_IDLE);

endmodule

// File: tb/tb_kfmmc_access_arbiter.sv
// Directed self-checking bench for kfmmc_access_arbiter; the bench itself plays the drive.
module tb_kfmmc_access_arbiter;

    localparam logic [31:0] ADDR_0 = 32'h12345678;
    localparam logic [7:0]  CMD_0  = 8'h80;
    localparam logic [31:0] ADDR_1 = 32'hA1B2C3D4;
    localparam logic [7:0]  CMD_1  = 8'h5C;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_block_address_0;
    logic [31:0] req_block_address_1;
    logic [7:0]  req_command_0;
    logic [7:0]  req_command_1;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_ready;
    logic [7:0]  rd_data;
    logic [1:0]  done;
    logic        done_interface_error;
    logic        done_crc_error;
    logic [7:0]  internal_data_bus;
    logic        write_block_address_1;
    logic        write_block_address_2;
    logic        write_block_address_3;
    logic        write_block_address_4;
    logic        write_access_command;
    logic        read_data;
    logic [7:0]  read_data_byte;
    logic        drive_busy;
    logic        read_interface_error;
    logic        read_crc_error;
    logic        block_read_interrupt;
    logic        read_completion_interrupt;
    logic        owner;
    logic        busy;

    int          nVec = 0;
    int          nMis = 0;
    int          nHs  = 0;
    int          nRd  = 0;
    logic        rdReadyEn = 1'b0;
    logic        tbOwner   = 1'b0;
    logic [7:0]  expQ[$];
    logic [13:0] hdrQ[$];

    kfmmc_access_arbiter #(
        .BLOCK_BYTES      (512),
        .DEFAULT_PRIORITY (0)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_block_address_0       (req_block_address_0),
        .req_block_address_1       (req_block_address_1),
        .req_command_0             (req_command_0),
        .req_command_1             (req_command_1),
        .rd_valid                  (rd_valid),
        .rd_ready                  (rd_ready),
        .rd_data                   (rd_data),
        .done                      (done),
        .done_interface_error      (done_interface_error),
        .done_crc_error            (done_crc_error),
        .internal_data_bus         (internal_data_bus),
        .write_block_address_1     (write_block_address_1),
        .write_block_address_2     (write_block_address_2),
        .write_block_address_3     (write_block_address_3),
        .write_block_address_4     (write_block_address_4),
        .write_access_command      (write_access_command),
        .read_data                 (read_data),
        .read_data_byte            (read_data_byte),
        .drive_busy                (drive_busy),
        .read_interface_error      (read_interface_error),
        .read_crc_error            (read_crc_error),
        .block_read_interrupt      (block_read_interrupt),
        .read_completion_interrupt (read_completion_interrupt),
        .owner                     (owner),
        .busy                      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] oneHot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [5:0] strobes();
        return {write_block_address_1, write_block_address_2, write_block_address_3,
                write_block_address_4, write_access_command, read_data};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] reqv);
        req_block_address_0 = ADDR_0;
        req_command_0       = CMD_0;
        req_block_address_1 = ADDR_1;
        req_command_1       = CMD_1;
        req_valid           = reqv;
    endtask

    // Grant, then the five write strobes, ending on the WAIT_BUSY cycle.
    task automatic runHeader(input logic [1:0] reqv, input logic expIdx, input logic keep);
        logic [31:0] a;
        logic [7:0]  c;
        logic [13:0] e;
        applyStimulus(reqv);
        #1;
        checkOutput("reqReady", 32'(req_ready), 32'(oneHot(expIdx)));
        a = expIdx ? ADDR_1 : ADDR_0;
        c = expIdx ? CMD_1 : CMD_0;
        hdrQ.push_back({6'b100000, a[31:24]});
        hdrQ.push_back({6'b010000, a[23:16]});
        hdrQ.push_back({6'b001000, a[15:8]});
        hdrQ.push_back({6'b000100, a[7:0]});
        hdrQ.push_back({6'b000010, c});
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0 && !keep) req_valid = 2'b00;
            e = hdrQ.pop_front();
            checkOutput("hdrStep", 32'({strobes(), internal_data_bus}), 32'(e));
        end
        @(negedge clock);
        checkOutput("waitBusyQuiet", 32'({strobes(), internal_data_bus, req_ready}), 32'd0);
        checkOutput("waitBusyOwner", 32'({busy, owner}), 32'({1'b1, expIdx}));
    endtask

    task automatic waitDone(input logic [1:0] expDone, input logic expIfe, input logic expCrc,
                            input int budget);
        int i = 0;
        do begin
            @(negedge clock);
            i++;
        end while (done == 2'b00 && i < budget);
        checkOutput("donePulse", 32'({done, done_interface_error, done_crc_error}),
                    32'({expDone, expIfe, expCrc}));
    endtask

    task automatic shortAccess(input logic [1:0] reqv, input logic expIdx, input logic keep,
                               input logic viaBusy, input logic crc);
        runHeader(reqv, expIdx, keep);
        if (viaBusy) begin
            drive_busy = 1'b1;
            @(negedge clock);
        end
        read_completion_interrupt = 1'b1;
        read_crc_error            = crc;
        waitDone(oneHot(expIdx), 1'b0, crc, 20);
        @(negedge clock);
        checkOutput("idleAfterDone", 32'({busy, done}), 32'd0);
        drive_busy                = 1'b0;
        read_completion_interrupt = 1'b0;
        read_crc_error            = 1'b0;
    endtask

    // Drive side: supplies bytes on read_data and consumes the owner's read handshakes.
    initial begin
        logic       toggle;
        logic [7:0] e8;
        rd_ready       = 2'b00;
        read_data_byte = 8'h00;
        toggle         = 1'b0;
        forever begin
            @(negedge clock);
            if (read_data) begin
                read_data_byte = 8'(nRd * 13 + 5 + nRd / 256);
                expQ.push_back(read_data_byte);
                nRd++;
            end
            toggle   = ~toggle;
            rd_ready = rdReadyEn ? {toggle, toggle} : 2'b00;
            if ((rd_valid & rd_ready) != 2'b00) begin
                checkOutput("rdValidOwner", 32'(rd_valid), 32'(oneHot(tbOwner)));
                checkOutput("rdQueued", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e8 = expQ.pop_front();
                    checkOutput("rdByte", 32'(rd_data), 32'(e8));
                end
                nHs++;
            end
            checkOutput("strobeOneHot", 32'($countones(strobes()) <= 1), 32'd1);
            checkOutput("busQuiet", (strobes() & 6'b111110) == 6'b0 ? 32'(internal_data_bus) : 32'd0,
                        32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   i;
        logic doneSeen;
        reset                     = 1'b0;
        req_valid                 = 2'b00;
        req_block_address_0       = 32'h0;
        req_block_address_1       = 32'h0;
        req_command_0             = 8'h00;
        req_command_1             = 8'h00;
        drive_busy                = 1'b0;
        read_interface_error      = 1'b0;
        read_crc_error            = 1'b0;
        block_read_interrupt      = 1'b0;
        read_completion_interrupt = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resetOutputs", 32'({req_ready, rd_valid, done, done_interface_error, done_crc_error,
                    strobes(), busy}), 32'd0);
        checkOutput("resetBusData", 32'({internal_data_bus, rd_data}), 32'd0);
        checkOutput("resetOwner", 32'(owner), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] single requester header, request dropped after grant");
        shortAccess(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] round-robin under contention from reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        shortAccess(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        shortAccess(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        shortAccess(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        req_valid = 2'b00;

        $display("[TB] one block with toggling rd_ready");
        tbOwner = 1'b1;
        runHeader(2'b10, 1'b1, 1'b0);
        drive_busy = 1'b1;
        @(negedge clock);
        nHs = 0;
        nRd = 0;
        rdReadyEn = 1'b1;
        block_read_interrupt = 1'b1;
        i = 0;
        while (nHs < 512 && i < 5000) begin
            @(negedge clock);
            i++;
        end
        repeat (10) @(negedge clock);
        checkOutput("blkHandshakes", 32'(nHs), 32'd512);
        checkOutput("blkStrobes", 32'(nRd), 32'd512);
        checkOutput("blkQueueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("blkWaitEvent", 32'({busy, rd_valid, done}), 32'({1'b1, 2'b00, 2'b00}));
        block_read_interrupt = 1'b0;
        read_completion_interrupt = 1'b1;
        waitDone(2'b10, 1'b0, 1'b0, 20);
        @(negedge clock);
        checkOutput("blkIdle", 32'(busy), 32'd0);
        read_completion_interrupt = 1'b0;
        drive_busy = 1'b0;

        $display("[TB] block and completion edges together");
        tbOwner = 1'b0;
        runHeader(2'b01, 1'b0, 1'b0);
        drive_busy = 1'b1;
        @(negedge clock);
        nHs = 0;
        nRd = 0;
        read_interface_error      = 1'b1;
        block_read_interrupt      = 1'b1;
        read_completion_interrupt = 1'b1;
        waitDone(2'b01, 1'b1, 1'b0, 6000);
        checkOutput("bothHandshakes", 32'(nHs), 32'd512);
        checkOutput("bothQueueEmpty", 32'(expQ.size()), 32'd0);
        @(negedge clock);
        checkOutput("bothIdle", 32'(busy), 32'd0);
        read_interface_error      = 1'b0;
        block_read_interrupt      = 1'b0;
        read_completion_interrupt = 1'b0;
        drive_busy                = 1'b0;
        rdReadyEn                 = 1'b0;

        $display("[TB] crc error on completion straight from WAIT_BUSY");
        shortAccess(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset while a byte is held");
        tbOwner = 1'b0;
        runHeader(2'b01, 1'b0, 1'b0);
        drive_busy = 1'b1;
        @(negedge clock);
        block_read_interrupt = 1'b1;
        i = 0;
        while (rd_valid == 2'b00 && i < 20) begin
            @(negedge clock);
            i++;
        end
        checkOutput("holdReached", 32'(rd_valid), 32'(2'b01));
        req_valid = 2'b01;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midResetOutputs", 32'({req_ready, rd_valid, done, done_interface_error, done_crc_error,
                    strobes(), busy}), 32'd0);
        checkOutput("midResetBusData", 32'({internal_data_bus, rd_data}), 32'd0);
        checkOutput("midResetOwner", 32'(owner), 32'd1);
        @(negedge clock);
        req_valid = 2'b00;
        block_read_interrupt = 1'b0;
        drive_busy = 1'b0;
        expQ.delete();
        @(negedge clock);
        reset = 1'b1;
        doneSeen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done != 2'b00) doneSeen = 1'b1;
        end
        checkOutput("noDoneAfterReset", 32'(doneSeen), 32'd0);
        checkOutput("idleAfterReset", 32'({busy, rd_valid}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/kfmmc_access_arbiter.md
KFMMC_ACCESS_ARBITER -- requirements
Module: kfmmc_access_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  BLOCK_BYTES, 512, bytes read per block_read_interrupt.
  DEFAULT_PRIORITY, 0, requester favoured on the first arbitration after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  single clock; all logic on its rising edge.
  reset  in  1  asynchronous, active-low reset.
  req_valid  in  2  per-requester access request.
  req_ready  out  2  request accepted (one-cycle pulse, owner only).
  req_block_address_0 / _1  in  32  block address per requester.
  req_command_0 / _1  in  8  access command byte per requester.
  rd_valid  out  2  read byte valid for owner.
  rd_ready  in  2  owner accepts byte.
  rd_data  out  8  read byte (shared).
  done  out  2  access finished (one-cycle pulse to owner).
  done_interface_error / done_crc_error  out  1  error flags, valid with done.
  internal_data_bus  out  8  byte to drive.
  write_block_address_1..4, write_access_command, read_data  out  1 each  drive strobes.
  read_data_byte  in  8  drive byte.
  drive_busy, read_interface_error, read_crc_error, block_read_interrupt, read_completion_interrupt  in  1 each  drive status.
  owner  out  1  current grant index; busy  out  1  grant held.

Function
REQ-003 States SHALL be IDLE, ADDR1, ADDR2, ADDR3, ADDR4, CMD, WAIT_BUSY, WAIT_EVENT, RD_STROBE, RD_CAPTURE, RD_HOLD, DONE.
REQ-004 Arbitration in IDLE SHALL be round-robin: with both req_valid high, grant the requester not granted last; after reset, DEFAULT_PRIORITY wins.
REQ-005 On grant, IDLE SHALL pulse req_ready[owner], latch address and command, and go to ADDR1 next cycle.
REQ-006 ADDR1..ADDR4 SHALL each drive one strobe for one cycle with internal_data_bus = address[31:24], [23:16], [15:8], [7:0] respectively.
REQ-007 CMD SHALL pulse write_access_command for one cycle with the latched command byte; first strobe occurs 1 cycle after grant, command strobe 5 cycles after grant.
REQ-008 WAIT_BUSY SHALL wait for drive_busy=1 then enter WAIT_EVENT; if read_completion_interrupt rises first, go directly to DONE.
REQ-009 Interrupt inputs SHALL be rising-edge detected with one registered sample; only edges act.
REQ-010 In WAIT_EVENT, a block_read_interrupt edge SHALL load byte counter with BLOCK_BYTES and enter RD_STROBE; a read_completion_interrupt edge SHALL enter DONE; a simultaneous edge of both SHALL take the block first and hold the completion pending.
REQ-011 RD_STROBE SHALL pulse read_data one cycle; RD_CAPTURE SHALL register read_data_byte into rd_data; RD_HOLD SHALL assert rd_valid[owner] until rd_ready[owner]=1.
REQ-012 Each accepted byte SHALL decrement the counter; at zero return to WAIT_EVENT (or DONE if completion pending), else RD_STROBE.
REQ-013 Byte counter SHALL be 10 bits; BLOCK_BYTES above 1023 is illegal.
REQ-014 DONE SHALL pulse done[owner] for one cycle with error flags sampled from the drive that cycle, then enter IDLE, releasing the grant.
REQ-015 A req_valid drop from the owner after acceptance SHALL be ignored; the access SHALL complete.
REQ-016 All strobes SHALL be mutually exclusive and zero outside their states; internal_data_bus SHALL be 8'h00 when no write strobe is active.

Reset
REQ-017 Reset low SHALL immediately force IDLE, all strobes/ready/valid/done 0, rd_data 0, owner = DEFAULT_PRIORITY's complement, busy 0, pending and edge registers 0, regardless of operation in progress.

Structure
REQ-018 State enum and strobe-index constants SHALL live in package kfmmc_arbiter_pkg.
REQ-019 Round-robin selection SHALL be sub-module kfmmc_round_robin_2 (inputs request[1:0], last; output grant index, grant_valid).

Verification
REQ-020 Requester 0 only, address 32'h12345678, cmd 8'h80 -> strobes on cycles +1..+5 with bus 12,34,56,78,80.
REQ-021 Both valid after reset, DEFAULT_PRIORITY=0 -> grants 0, then 1, then 0 over three accesses.
REQ-022 One block of 512 bytes, rd_ready toggling 50% -> exactly 512 rd_valid handshakes, 512 read_data pulses, bytes in order.
REQ-023 Block and completion edges in the same cycle -> 512 bytes delivered, then done with flags.
REQ-024 read_crc_error=1 at completion -> done pulse with done_crc_error=1, arbiter back in IDLE next cycle.
REQ-025 Reset asserted in RD_HOLD -> all outputs 0 same cycle, IDLE after release, no done pulse.
